// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
// Bundles the command stream, the response stream and the Wishbone classic
// bus seen by wb_cmd_master into a single interface.
//
// Signals
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i   command payload
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o        response payload
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o   Wishbone request
//   wb_dat_i, wb_ack_i, wb_err_i                                Wishbone reply
//
// Modports
//   master : the wb_cmd_master block itself (Wishbone initiator side)
//   slave  : the environment (command source, response sink, Wishbone slave)
// ---------------------------------------------------------------------------
interface wb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_W-1:0]     cmd_adr_i;
    logic [DATA_W-1:0]     cmd_dat_i;
    logic [DATA_W/8-1:0]   cmd_sel_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_dat_o;
    logic                  rsp_err_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
// Wishbone classic single-transfer initiator. One accepted command becomes
// exactly one Wishbone read or write cycle; the outcome is returned on the
// response stream. Only one transfer is ever outstanding.
//
// Ports
//   clk_i    : clock, all logic on the rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : wb_cmd_master_if.master (command, response, Wishbone signals)
//
// Parameters
//   ADDR_W      : address width
//   DATA_W      : data width, multiple of 8
//   TIMEOUT_CYC : BUS-state cycle limit, 1..65535 (timeout build only)
//
// Optional feature macro
//   WBM_TIMEOUT_EN : when defined, a BUS cycle that sees neither ack nor err
//                    for TIMEOUT_CYC cycles is aborted with an error response.
//                    When undefined, BUS waits for ack or err forever.
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_cmd_master_if.master   bus
);

    // Reject parameter sets the datapath cannot represent.
    generate
        if ((DATA_W % 8) != 0 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : gParamCheck
            $error("wb_cmd_master: illegal DATA_W or TIMEOUT_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_cmdReady;
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_adr;
    logic [DATA_W-1:0]     r_dat;
    logic [DATA_W/8-1:0]   r_sel;
    logic                  r_rspValid;
    logic [DATA_W-1:0]     r_rspDat;
    logic                  r_rspErr;
    logic                  w_cmdFire;

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]           r_waitCnt;
    logic                  w_timeout;

    // The final permitted BUS cycle is the one where the count reaches
    // TIMEOUT_CYC-1; ack/err in that cycle still win over the abort.
    assign w_timeout = (r_waitCnt == TO_LAST);
`endif

    assign w_cmdFire = r_cmdReady & bus.cmd_valid_i;

    // Single registered FSM. Every output is a flop so the Wishbone side
    // never sees combinational paths from the command or response streams.
    // cmd_ready is only raised from the first edge after reset release,
    // and is re-raised on RESP exit so the next command can be taken
    // immediately in the following cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_rspValid <= 1'b0;
            r_rspDat   <= '0;
            r_rspErr   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            r_waitCnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmdReady <= 1'b1;
                    if (w_cmdFire) begin
                        r_cmdReady <= 1'b0;
                        r_we       <= bus.cmd_we_i;
                        r_adr      <= bus.cmd_adr_i;
                        r_dat      <= bus.cmd_dat_i;
                        r_sel      <= bus.cmd_sel_i;
                        r_cyc      <= 1'b1;
`ifdef WBM_TIMEOUT_EN
                        r_waitCnt  <= '0;
`endif
                        r_state    <= BUS;
                    end
                end

                BUS: begin
                    if (bus.wb_err_i) begin
                        r_cyc      <= 1'b0;
                        r_rspDat   <= '0;
                        r_rspErr   <= 1'b1;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else if (bus.wb_ack_i) begin
                        r_cyc      <= 1'b0;
                        r_rspDat   <= r_we ? '0 : bus.wb_dat_i;
                        r_rspErr   <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end
`ifdef WBM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_cyc      <= 1'b0;
                        r_rspDat   <= '0;
                        r_rspErr   <= 1'b1;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_waitCnt  <= r_waitCnt + 16'd1;
                    end
`endif
                end

                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_state    <= IDLE;
                    end
                end

                default: begin
                    r_cyc      <= 1'b0;
                    r_rspValid <= 1'b0;
                    r_cmdReady <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = r_cmdReady;
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_stb_o    = r_cyc;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_adr_o    = r_adr;
    assign bus.wb_dat_o    = r_dat;
    assign bus.wb_sel_o    = r_sel;
    assign bus.rsp_valid_o = r_rspValid;
    assign bus.rsp_dat_o   = r_rspDat;
    assign bus.rsp_err_o   = r_rspErr;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master. Inputs are driven and outputs sampled on
// the falling clock edge, midway between the rising edges the design uses.
// The timeout scenario is only exercised when WBM_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk;
    logic rstN;
    int   vectorCount;
    int   missCount;
    int   cycHigh;
    logic weSeen;
    int   badCyc;

    wb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_cmd_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one observed value with its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command from an idle falling edge, plays the Wishbone slave
    // (waits, then ack/err with read data) and returns at the falling edge
    // of the first cycle after cyc drops, counting cyc-high cycles.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input int waits, input logic doAck,
                                 input logic doErr, input logic [31:0] rdData,
                                 output int cycCnt, output logic weFirst);
        int guard;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        weFirst = bus.wb_we_o;
        cycCnt  = 0;
        for (int i = 0; i < waits; i++) begin
            if (bus.wb_cyc_o) cycCnt++;
            @(negedge clk);
        end
        if (bus.wb_cyc_o) cycCnt++;
        bus.wb_ack_i = doAck;
        bus.wb_err_i = doErr;
        bus.wb_dat_i = rdData;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = 32'hBAD0_BAD0;
        guard = 0;
        while (bus.wb_cyc_o && guard < 40) begin
            cycCnt++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 40) checkOutput("cycBound", 64'd1, 64'd0);
    endtask

    initial begin
        vectorCount     = 0;
        missCount       = 0;
        rstN            = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b1;
        bus.wb_dat_i    = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;

        // Reset values while reset is held.
        @(negedge clk);
        checkOutput("rstCmdReady", bus.cmd_ready_o, 0);
        checkOutput("rstCyc", bus.wb_cyc_o, 0);
        checkOutput("rstStb", bus.wb_stb_o, 0);
        checkOutput("rstAdr", bus.wb_adr_o, 0);
        checkOutput("rstRspValid", bus.rsp_valid_o, 0);
        checkOutput("rstRspDat", bus.rsp_dat_o, 0);
        checkOutput("rstRspErr", bus.rsp_err_o, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("relCmdReady", bus.cmd_ready_o, 1);

        // Write with two wait states.
        applyStimulus(1'b1, 32'h0000_00A4, 32'h1234_5678, 4'hF, 2, 1'b1, 1'b0,
                      32'hFFFF_FFFF, cycHigh, weSeen);
        checkOutput("wrCycLen", cycHigh, 3);
        checkOutput("wrWe", weSeen, 1);
        checkOutput("wrAdr", bus.wb_adr_o, 32'h0000_00A4);
        checkOutput("wrDat", bus.wb_dat_o, 32'h1234_5678);
        checkOutput("wrSel", bus.wb_sel_o, 4'hF);
        checkOutput("wrRspValid", bus.rsp_valid_o, 1);
        checkOutput("wrRspErr", bus.rsp_err_o, 0);
        checkOutput("wrRspDat", bus.rsp_dat_o, 0);
        @(negedge clk);
        checkOutput("wrRspDrop", bus.rsp_valid_o, 0);
        checkOutput("wrNextReady", bus.cmd_ready_o, 1);

        // Zero-wait read.
        applyStimulus(1'b0, 32'h0000_0008, 32'h0, 4'hF, 0, 1'b1, 1'b0,
                      32'hCAFE_F00D, cycHigh, weSeen);
        checkOutput("rdCycLen", cycHigh, 1);
        checkOutput("rdWe", weSeen, 0);
        checkOutput("rdRspValid", bus.rsp_valid_o, 1);
        checkOutput("rdRspDat", bus.rsp_dat_o, 32'hCAFE_F00D);
        checkOutput("rdRspErr", bus.rsp_err_o, 0);
        @(negedge clk);

        // Ack and err together: err must win.
        applyStimulus(1'b0, 32'h0000_000C, 32'h0, 4'hF, 1, 1'b1, 1'b1,
                      32'hDEAD_BEEF, cycHigh, weSeen);
        checkOutput("bothCycLen", cycHigh, 2);
        checkOutput("bothRspErr", bus.rsp_err_o, 1);
        checkOutput("bothRspDat", bus.rsp_dat_o, 0);
        @(negedge clk);

`ifdef WBM_TIMEOUT_EN
        // Slave never answers: abort after four BUS cycles.
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 1'b0, 1'b0,
                      32'h1111_1111, cycHigh, weSeen);
        checkOutput("toCycLen", cycHigh, 4);
        checkOutput("toRspValid", bus.rsp_valid_o, 1);
        checkOutput("toRspErr", bus.rsp_err_o, 1);
        checkOutput("toRspDat", bus.rsp_dat_o, 0);
        @(negedge clk);
`endif

        // Response back-pressure blocks new commands.
        bus.rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1'b1, 1'b0,
                      32'h0000_55AA, cycHigh, weSeen);
        checkOutput("bpRspValid", bus.rsp_valid_o, 1);
        checkOutput("bpRspDat", bus.rsp_dat_o, 32'h0000_55AA);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 32'h0000_0010;
        bus.cmd_dat_i   = 32'hA5A5_A5A5;
        bus.cmd_sel_i   = 4'h3;
        badCyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o || bus.wb_cyc_o || !bus.rsp_valid_o) badCyc++;
        end
        checkOutput("bpBlocked", badCyc, 0);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("bpIdleCyc", bus.wb_cyc_o, 0);
        checkOutput("bpIdleReady", bus.cmd_ready_o, 1);
        checkOutput("bpIdleValid", bus.rsp_valid_o, 0);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        checkOutput("bpNextCyc", bus.wb_cyc_o, 1);
        checkOutput("bpNextAdr", bus.wb_adr_o, 32'h0000_0010);
        checkOutput("bpNextSel", bus.wb_sel_o, 4'h3);
        checkOutput("bpNextWe", bus.wb_we_o, 1);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h7777_7777;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        checkOutput("bpWrValid", bus.rsp_valid_o, 1);
        checkOutput("bpWrDat", bus.rsp_dat_o, 0);
        @(negedge clk);

        // Reset in the second BUS cycle, late ack after release.
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0000_0030;
        bus.cmd_sel_i   = 4'hF;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        checkOutput("mrFirstBus", bus.wb_cyc_o, 1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("mrCycDrop", bus.wb_cyc_o, 0);
        checkOutput("mrStbDrop", bus.wb_stb_o, 0);
        checkOutput("mrReadyLow", bus.cmd_ready_o, 0);
        @(negedge clk);
        rstN = 1'b1;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h9999_9999;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        checkOutput("mrNoRsp", bus.rsp_valid_o, 0);
        checkOutput("mrCycIdle", bus.wb_cyc_o, 0);
        checkOutput("mrCmdReady", bus.cmd_ready_o, 1);
        @(negedge clk);
        checkOutput("mrNoRspLater", bus.rsp_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
